stopwatch_timer: RTL
====================

STOPWATCH_TIMER -- requirements
Module: stopwatch_timer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clock.
REQ-002 Parameter: TICK_DIV, 500000, clock cycles per centisecond tick (50 MHz / 100).
REQ-003 Port: clock  input  1  system clock (50 MHz).
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: run_timer  input  1  level; 1 = count, 0 = paused (from key logic FSM).
REQ-006 Port: reset_timer  input  1  single-cycle pulse; clear time to zero.
REQ-007 Port: lap_timer  input  1  single-cycle pulse; toggle lap hold.
REQ-008 Port: hour  output  6  displayed hours, 0..23.
REQ-009 Port: minute  output  6  displayed minutes, 0..59.
REQ-010 Port: second  output  6  displayed seconds, 0..59.
REQ-011 Port: m_sec  output  7  displayed centiseconds, 0..99.
REQ-012 Port: lap_active  output  1  1 while display is frozen on a lap value.
REQ-013 Port: day_wrap  output  1  one-cycle pulse on 23:59:59.99 -> 00:00:00.00.

Function
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 only while run_timer=1; at TICK_DIV-1 with run_timer=1 it SHALL return to 0 and assert an internal tick that cycle.
REQ-015 While run_timer=0 the prescaler and live time SHALL hold their values (pause preserves sub-tick phase).
REQ-016 On tick, live time SHALL increment by one centisecond; the new value SHALL be visible on outputs the next cycle (1-cycle latency from tick).
REQ-017 Cascade: m_sec 99->0 carries to second; second 59->0 carries to minute; minute 59->0 carries to hour; hour 23->0.
REQ-018 day_wrap SHALL pulse for exactly the cycle following the 23:59:59.99 -> 00:00:00.00 increment; counting SHALL continue.
REQ-019 Lap state machine: states LIVE (lap_active=0) and HOLD (lap_active=1).
REQ-020 LIVE + lap_timer: latch current registered live time (pre-increment if a tick coincides) into lap registers, go to HOLD.
REQ-021 HOLD + lap_timer: go to LIVE; lap registers unchanged.
REQ-022 Outputs SHALL show lap registers in HOLD and live time in LIVE; live time SHALL keep counting in HOLD when run_timer=1.
REQ-023 lap_timer SHALL be honoured regardless of run_timer.
REQ-024 reset_timer SHALL clear prescaler, live time, lap registers, and return to LIVE; it SHALL have priority over tick and lap_timer in the same cycle.
REQ-025 reset_timer SHALL not alter run_timer behaviour: if run_timer=1, counting restarts from 0 the cycle after clear.
REQ-026 All counter widths SHALL be exact as listed; no value outside stated ranges SHALL ever appear on outputs.

Reset
REQ-027 reset=1 SHALL have the effect of reset_timer and SHALL also deassert day_wrap; after reset all outputs SHALL be 0, state LIVE.
REQ-028 reset asserted mid-count SHALL clear all state on that edge regardless of run_timer, reset_timer, lap_timer.

Verification (TICK_DIV=4)
REQ-029 reset, run_timer=1 for 400 cycles -> second=1, m_sec=0, hour=minute=0.
REQ-030 run 10 cycles, run_timer=0 for 50 cycles, run 6 cycles -> m_sec=4 (16 counted cycles), no change during pause.
REQ-031 preload via run to 00:00:59.99, one more tick -> minute=1, second=0, m_sec=0; from 23:59:59.99 next tick -> all 0 and day_wrap high one cycle.
REQ-032 run to m_sec=25, lap_timer pulse -> outputs frozen at 25, lap_active=1 while live advances; second lap_timer -> outputs jump to live value, lap_active=0.
REQ-033 reset_timer and lap_timer same cycle while in HOLD at m_sec=40 -> all outputs 0, lap_active=0.
REQ-034 lap_timer coinciding with tick at m_sec=7 -> lap shows 7, live becomes 8.

Source files
------------

// File: rtl/stopwatch_timer.sv
// Stopwatch with centisecond resolution, 24-hour rollover and a lap-hold display.
// Live time always runs underneath; the display shows either live time or the frozen lap value.
module stopwatch_timer #(
  parameter int TICK_DIV = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run_timer,
  input  logic       reset_timer,
  input  logic       lap_timer,
  output logic [5:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [6:0] m_sec,
  output logic       lap_active,
  output logic       day_wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef struct packed {
    logic [5:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [6:0] csec;
  } tod_t;

  localparam tod_t DAY_LAST = '{hour: 6'd23, minute: 6'd59, second: 6'd59, csec: 7'd99};

  typedef enum logic {LIVE = 1'b0, HOLD = 1'b1} lap_state_t;

  lap_state_t    state, state_nxt;
  logic          lap_load;
  logic          tick;
  logic          clear;
  logic [PW-1:0] pre_cnt;
  tod_t          live;
  tod_t          lap;
  tod_t          disp;

  function automatic tod_t tod_inc(input tod_t t);
    tod_t r;
    r = t;
    if (t.csec == 7'd99) begin
      r.csec = 7'd0;
      if (t.second == 6'd59) begin
        r.second = 6'd0;
        if (t.minute == 6'd59) begin
          r.minute = 6'd0;
          r.hour   = (t.hour == 6'd23) ? 6'd0 : t.hour + 6'd1;
        end else begin
          r.minute = t.minute + 6'd1;
        end
      end else begin
        r.second = t.second + 6'd1;
      end
    end else begin
      r.csec = t.csec + 7'd1;
    end
    return r;
  endfunction

  assign clear = reset | reset_timer;
  assign tick  = run_timer && (pre_cnt == PRE_MAX);

  always_comb begin
    state_nxt = state;
    lap_load  = 1'b0;
    if (lap_timer) begin
      case (state)
        LIVE: begin
          state_nxt = HOLD;
          lap_load  = 1'b1;
        end
        HOLD:    state_nxt = LIVE;
        default: state_nxt = LIVE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clear) state <= LIVE;
    else       state <= state_nxt;
  end

  // Prescaler only advances while running, so a pause keeps the sub-tick phase.
  always_ff @(posedge clock) begin
    if (clear)          pre_cnt <= '0;
    else if (run_timer) pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (clear)     live <= '0;
    else if (tick) live <= tod_inc(live);
  end

  // Lap captures the registered live value, i.e. before a coinciding tick.
  always_ff @(posedge clock) begin
    if (clear)         lap <= '0;
    else if (lap_load) lap <= live;
  end

  always_ff @(posedge clock) begin
    if (clear) day_wrap <= 1'b0;
    else       day_wrap <= tick && (live == DAY_LAST);
  end

  assign disp       = (state == HOLD) ? lap : live;
  assign hour       = disp.hour;
  assign minute     = disp.minute;
  assign second     = disp.second;
  assign m_sec      = disp.csec;
  assign lap_active = (state == HOLD);

endmodule
